// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NEG = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle.
// o_done_c and o_product_c are valid together on the final iteration cycle.
module shift_add_mul
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done_c,
    output logic [2*WIDTH-1:0]   o_product_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    w_acc_next;

    // Accumulate the multiplicand whenever the current multiplier LSB is set.
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done_c    = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_product_c = w_acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= PW'(i_a);
            r_acc    <= '0;
            r_mplier <= i_b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (o_done_c) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Clocked opcode-select ALU with valid/ready handshakes on operands and result.
// Single-cycle ops go through EXEC; MUL runs the iterative multiplier.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic [2:0]           sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 cout,
    output logic                 err
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned SW = WIDTH + 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [2:0]       r_sel;
    logic [RW-1:0]    r_result;
    logic             r_cout;
    logic             r_err;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [RW-1:0]    w_mul_product;
    logic [SW-1:0]    w_sum;
    logic [SW-1:0]    w_diff;
    logic [WIDTH-1:0] w_neg;
    logic [RW-1:0]    w_alu_result;
    logic             w_alu_cout;
    logic             w_alu_err;

    assign in_ready    = (r_state == ST_IDLE);
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (sel == OP_MUL);

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign err       = r_err;

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_mul_start),
        .i_a         (a),
        .i_b         (b),
        .o_done_c    (w_mul_done),
        .o_product_c (w_mul_product)
    );

    // Top bit of the extended sum/difference is the carry/borrow.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b} + SW'(r_cin);
    assign w_diff = {1'b0, r_a} - {1'b0, r_b} - SW'(r_cin);
    assign w_neg  = ~r_b + WIDTH'(1);

    always_comb begin
        w_alu_result = '0;
        w_alu_cout   = 1'b0;
        w_alu_err    = 1'b0;
        case (r_sel)
            OP_ADD: begin
                w_alu_result = RW'(w_sum);
                w_alu_cout   = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu_result = RW'(w_diff);
                w_alu_cout   = w_diff[WIDTH];
            end
            OP_AND:  w_alu_result = RW'(r_a & r_b);
            OP_OR:   w_alu_result = RW'(r_a | r_b);
            OP_XOR:  w_alu_result = RW'(r_a ^ r_b);
            OP_NEG:  w_alu_result = RW'(w_neg);
            OP_ILL:  w_alu_err    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_sel       <= '0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_cin   <= cin;
                        r_sel   <= sel;
                        r_state <= (sel == OP_MUL) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result    <= w_alu_result;
                    r_cout      <= w_alu_cout;
                    r_err       <= w_alu_err;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_result    <= w_mul_product;
                        r_cout      <= 1'b0;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result stays frozen until the consumer takes it.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
